// File: rtl/bias_relu_serializer.sv
// bias_relu_serializer
//   Captures one ROWS x COLS result matrix plus per-element bias in a single
//   handshake, then streams bias-added, ReLU-clamped, saturated elements out
//   one per cycle in row-major order.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no frame buffered, in_ready=1, out_valid=0
//   STREAM | frame buffered, out_valid=1, presenting element out_index
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   in_valid   in_matrix/in_bias carry a complete frame
//   in_ready   frame can be accepted this cycle (combinational from out_ready)
//   in_matrix  packed elements, element e at [e*DATA_W +: DATA_W]
//   in_bias    packed per-element bias, same layout
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_data   activated element
//   out_index  element index row*COLS+col
//   out_last   out_data is the final element of the frame
//   frame_cnt  frames fully emitted since reset, wraps modulo 2^16
module bias_relu_serializer #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_matrix,
  input  logic [N*DATA_W-1:0]   in_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic [15:0]           frame_cnt
);

  // Bias and data share the same Q format, so FRAC only constrains legality.
  if (FRAC < 0 || FRAC >= DATA_W) begin : g_frac_check
    $error("FRAC must lie in [0, DATA_W)");
  end

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t            state;
  logic [DATA_W-1:0] x_buf [N];
  logic [DATA_W-1:0] b_buf [N];
  logic [IDX_W-1:0]  nxt_idx;
  logic              out_hs;
  logic              accept;

  // Sum at DATA_W+1 bits cannot overflow; the top bit is the true sign and
  // bit DATA_W-1 set on a non-negative sum means it exceeds the positive max.
  function automatic logic [DATA_W-1:0] relu_sat(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {x[DATA_W-1], x} + {b[DATA_W-1], b};
    if (s[DATA_W])
      return '0;
    else if (s[DATA_W-1])
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return s[DATA_W-1:0];
  endfunction

  assign out_hs   = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (out_hs && out_last);
  assign accept   = in_valid && in_ready;
  assign nxt_idx  = out_index + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < N; i++) begin
        x_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else begin
      if (out_hs && out_last)
        frame_cnt <= frame_cnt + 16'd1;

      // A new frame wins over the final-element retire so back-to-back frames
      // continue with element 0 and no idle cycle.
      if (accept) begin
        for (int i = 0; i < N; i++) begin
          x_buf[i] <= in_matrix[i*DATA_W +: DATA_W];
          b_buf[i] <= in_bias[i*DATA_W +: DATA_W];
        end
        state     <= STREAM;
        out_valid <= 1'b1;
        out_index <= '0;
        out_last  <= (N == 1);
        out_data  <= relu_sat(in_matrix[DATA_W-1:0], in_bias[DATA_W-1:0]);
      end else if (out_hs) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_index <= '0;
          out_last  <= 1'b0;
        end else begin
          out_index <= nxt_idx;
          out_last  <= (nxt_idx == LAST_IDX);
          out_data  <= relu_sat(x_buf[nxt_idx], b_buf[nxt_idx]);
        end
      end
    end
  end

endmodule
